io_pwm: RTL
===========

# io_pwm

Four-channel PWM peripheral on the CPU's IO bus, chained into the `dma_io_rdata` read daisy chain like the other `io_*` blocks. It is placed between `io_frc` and the CPU, or at any other point in the chain. It provides:
- a programmable prescaler;
- a 16-bit period counter;
- four double-buffered duty registers.

Its outputs drive LED brightness or external pins. Duty and period updates take effect only at a period wrap, so outputs never glitch.

## Interface
- `IO_BASE` — default 14'h3FD0 — word address (`[15:2]`) of the register window, byte address 0xFF40; must be 8-word aligned.
- `clk` — in — 1 — system clock (`clk_wiz_0` output).
- `rst_n` — in — 1 — reset; one clock, synchronous, active-high (asserted = 1).
- `dma_io_we` — in — 1 — IO write strobe.
- `dma_io_wadr` — in — `[15:2]` — IO write word address.
- `dma_io_wdata` — in — 32 — IO write data.
- `dma_io_radr` — in — `[15:2]` — IO read word address.
- `dma_io_radr_en` — in — 1 — IO read strobe.
- `dma_io_rdata_in` — in — 32 — read data from the upstream chain stage.
- `dma_io_rdata` — out — 32 — read data to the downstream stage or the CPU.
- `pwm_out` — out — 4 — PWM outputs, channel i on bit i.
- `pwm_wrap` — out — 1 — one-cycle pulse at every period wrap.

## Operation
- Window hit: `adr[15:5] == IO_BASE[15:5]`. The register is selected by `adr[4:2]`.
- Register map (word offsets):
  - 0 CTRL: `[3:0]` ch_en, `[4]` run.
  - 1 PRESC: `[15:0]`.
  - 2 PERIOD: `[15:0]`.
  - 3 COUNT: read-only, `[15:0]` current counter; writes are ignored.
  - 4–7 DUTY0–DUTY3: `[15:0]`.
- Unused bits read 0 and are ignored on write.
- Programmed registers: ctrl, presc, period_sw, duty_sw[0..3]. Active copies: period_act, duty_act[0..3].
- Prescaler:
  - pres_cnt counts 0..presc.
  - tick = run & (pres_cnt == presc).
  - pres_cnt returns to 0 on tick.
  - presc = 0 gives a tick every cycle.
- Counter, on tick:
  - if cnt >= period_act: cnt <= 0, pwm_wrap <= 1, and period_act/duty_act load from the programmed copies;
  - else cnt <= cnt + 1.
  - The period is therefore (period_act + 1) × (presc + 1) clocks.
- While run = 0:
  - cnt and pres_cnt are held at 0;
  - active copies track the programmed copies every cycle, so configuration before start is immediate.
- Output: pwm_out[i] <= run & ch_en[i] & (cnt < duty_act[i]), registered.
  - duty = 0 gives constant low.
  - duty > period gives constant high.
  - period = 0 with duty >= 1 gives constant high.
- Read path:
  - On radr_en with hit: rd_hit_q <= 1, rd_data_q <= the addressed register.
  - Otherwise rd_hit_q <= 0.
  - dma_io_rdata = rd_hit_q ? rd_data_q : dma_io_rdata_in (combinational mux).
- A write to CTRL clearing run resets cnt and pres_cnt on the next edge.
- Simultaneous write to DUTYn and wrap on the same edge: the wrap loads the old duty_sw, and the new value applies at the following wrap.
- Simultaneous read and write to the same register: the read returns the pre-write value.

## Timing
- Reset values: all registers 0; pwm_out = 0; pwm_wrap = 0; rd_hit_q = 0; dma_io_rdata = dma_io_rdata_in.
- Write latency: a register is updated at the edge ending the cycle in which dma_io_we is high.
- Read latency: 1 cycle. Data is valid the cycle after dma_io_radr_en. The CPU samples it then, the same rule as the other io blocks.
- pwm_out lags cnt by 1 cycle.
- pwm_wrap is high for exactly the 1 cycle after the wrap edge.
- After run goes 1, the first tick occurs presc + 1 cycles later.
- Reset mid-period: all state clears on the next edge, and outputs are low the following cycle.

## Structure
- Shared package `io_pwm_pkg`:
  - register offsets (CTRL=0, PRESC=1, PERIOD=2, COUNT=3, DUTY0=4);
  - CTRL bit positions;
  - counter width 16;
  - channel count 4.
- The IO_BASE value belongs in the system IO address-map package alongside the other `io_*` bases.
- One natural sub-module: `io_pwm_chan` (duty shadow register, compare, output flop), instantiated ×4.
- Prescaler, counter, register file and read mux stay in the top.

## Test plan
- Reset then read each of offsets 0–7 with dma_io_rdata_in = 32'hA5A5A5A5:
  - window reads return 0;
  - a non-hit address returns 32'hA5A5A5A5 on the cycle after radr_en.
- PRESC = 0, PERIOD = 9, DUTY0 = 3, CTRL = 0x11:
  - pwm_out[0] is high 3 of every 10 cycles;
  - pwm_wrap pulses every 10 cycles;
  - COUNT reads stay within 0..9.
- Running with DUTY0 = 3, write DUTY0 = 7 mid-period:
  - the current period keeps 3 high cycles;
  - the next period has 7.
  - Repeat with the write landing on the wrap cycle: 7 appears one period later.
- Boundaries with PERIOD = 4:
  - DUTY1 = 0 gives constant low;
  - DUTY2 = 5 gives constant high;
  - PERIOD = 0 with DUTY3 = 1 gives constant high;
  - ch_en bit cleared forces that channel low.
- PRESC = 2, PERIOD = 3: the period is 12 clocks.
- Clear run mid-period:
  - outputs low within 2 cycles;
  - COUNT reads 0;
  - restart reproduces the first-period waveform.
- Assert rst_n for 1 cycle mid-run: all outputs and registers are 0 the next cycle.

Source files
------------

// File: rtl/io_pwm_pkg.sv
// Shared definitions for the io_pwm peripheral: register map, CTRL layout and sizing.
package io_pwm_pkg;

  // Word address of the io_pwm window; sits with the other io_* bases in the IO map.
  localparam logic [15:2] IO_PWM_BASE = 14'h3FD0;

  localparam int CNT_W  = 16;
  localparam int NUM_CH = 4;

  typedef enum logic [2:0] {
    REG_CTRL   = 3'd0,
    REG_PRESC  = 3'd1,
    REG_PERIOD = 3'd2,
    REG_COUNT  = 3'd3,
    REG_DUTY0  = 3'd4,
    REG_DUTY1  = 3'd5,
    REG_DUTY2  = 3'd6,
    REG_DUTY3  = 3'd7
  } reg_off_e;

  localparam int CTRL_CH_EN_LSB = 0;
  localparam int CTRL_RUN_BIT   = 4;
  localparam int CTRL_W         = 5;

  // Packed so that bit 4 is run and bits 3:0 are ch_en, matching the CTRL word.
  typedef struct packed {
    logic              run;
    logic [NUM_CH-1:0] ch_en;
  } ctrl_t;

endpackage

// File: rtl/io_pwm_chan.sv
// One PWM channel: programmed duty, active duty loaded on request, registered compare output.
module io_pwm_chan
  import io_pwm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [CNT_W-1:0] wdata_i,
  input  logic             load_i,
  input  logic             run_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic [CNT_W-1:0] duty_sw_o,
  output logic             pwm_o
);

  logic [CNT_W-1:0] duty_sw_q;
  logic [CNT_W-1:0] duty_act_q;
  logic             pwm_q;
  logic             pwm_d;

  assign pwm_d = run_i & en_i & (cnt_i < duty_act_q);

  // load_i samples the old duty_sw_q, so a write on a wrap edge waits one more period.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      duty_sw_q  <= '0;
      duty_act_q <= '0;
      pwm_q      <= 1'b0;
    end else begin
      if (wr_en_i) duty_sw_q  <= wdata_i;
      if (load_i)  duty_act_q <= duty_sw_q;
      pwm_q <= pwm_d;
    end
  end

  assign duty_sw_o = duty_sw_q;
  assign pwm_o     = pwm_q;

endmodule

// File: rtl/io_pwm.sv
// Four-channel PWM on the IO bus: prescaler, period counter, register file and chained read mux.
module io_pwm
  import io_pwm_pkg::*;
#(
  parameter logic [15:2] IO_BASE = IO_PWM_BASE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dma_io_we,
  input  logic [15:2] dma_io_wadr,
  input  logic [31:0] dma_io_wdata,
  input  logic [15:2] dma_io_radr,
  input  logic        dma_io_radr_en,
  input  logic [31:0] dma_io_rdata_in,
  output logic [31:0] dma_io_rdata,
  output logic [3:0]  pwm_out,
  output logic        pwm_wrap
);

  // IO bus: a write commits on the edge closing a dma_io_we cycle; read data is valid the
  // cycle after dma_io_radr_en with no backpressure, otherwise upstream data passes through.
  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] presc_q;
  logic [CNT_W-1:0] period_sw_q;
  logic [CNT_W-1:0] period_act_q;
  logic [CNT_W-1:0] pres_cnt_q, pres_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap_q;
  logic             rd_hit_q;
  logic [31:0]      rd_data_q;
  logic [31:0]      rd_mux;

  logic              wr_hit, rd_hit;
  reg_off_e          wr_off, rd_off;
  logic              tick, wrap_evt, act_load;
  logic [NUM_CH-1:0] duty_we;
  logic [NUM_CH-1:0] pwm_vec;
  logic [CNT_W-1:0]  duty_sw [NUM_CH];
  logic              unused_wdata_bits;

  assign unused_wdata_bits = ^dma_io_wdata[31:CNT_W];

  assign wr_hit = dma_io_we & (dma_io_wadr[15:5] == IO_BASE[15:5]);
  assign rd_hit = dma_io_radr_en & (dma_io_radr[15:5] == IO_BASE[15:5]);
  assign wr_off = reg_off_e'(dma_io_wadr[4:2]);
  assign rd_off = reg_off_e'(dma_io_radr[4:2]);

  assign tick     = ctrl_q.run & (pres_cnt_q == presc_q);
  assign wrap_evt = tick & (cnt_q >= period_act_q);
  // While stopped the active copies follow the programmed ones so setup applies at once.
  assign act_load = ~ctrl_q.run | wrap_evt;

  always_comb begin
    pres_cnt_d = pres_cnt_q;
    cnt_d      = cnt_q;
    if (!ctrl_q.run) begin
      pres_cnt_d = '0;
      cnt_d      = '0;
    end else if (tick) begin
      pres_cnt_d = '0;
      cnt_d      = wrap_evt ? '0 : cnt_q + 16'd1;
    end else begin
      pres_cnt_d = pres_cnt_q + 16'd1;
    end
  end

  always_comb begin
    duty_we = '0;
    if (wr_hit && dma_io_wadr[4]) duty_we[dma_io_wadr[3:2]] = 1'b1;
  end

  always_comb begin
    rd_mux = '0;
    case (rd_off)
      REG_CTRL:   rd_mux[CTRL_W-1:0] = ctrl_q;
      REG_PRESC:  rd_mux[CNT_W-1:0]  = presc_q;
      REG_PERIOD: rd_mux[CNT_W-1:0]  = period_sw_q;
      REG_COUNT:  rd_mux[CNT_W-1:0]  = cnt_q;
      default:    rd_mux[CNT_W-1:0]  = duty_sw[dma_io_radr[3:2]];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      ctrl_q       <= '0;
      presc_q      <= '0;
      period_sw_q  <= '0;
      period_act_q <= '0;
      pres_cnt_q   <= '0;
      cnt_q        <= '0;
      wrap_q       <= 1'b0;
      rd_hit_q     <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      if (wr_hit) begin
        case (wr_off)
          REG_CTRL:   ctrl_q      <= ctrl_t'(dma_io_wdata[CTRL_W-1:0]);
          REG_PRESC:  presc_q     <= dma_io_wdata[CNT_W-1:0];
          REG_PERIOD: period_sw_q <= dma_io_wdata[CNT_W-1:0];
          default: ;
        endcase
      end
      if (act_load) period_act_q <= period_sw_q;
      pres_cnt_q <= pres_cnt_d;
      cnt_q      <= cnt_d;
      wrap_q     <= wrap_evt;
      rd_hit_q   <= rd_hit;
      if (rd_hit) rd_data_q <= rd_mux;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    io_pwm_chan u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (duty_we[g]),
      .wdata_i   (dma_io_wdata[CNT_W-1:0]),
      .load_i    (act_load),
      .run_i     (ctrl_q.run),
      .en_i      (ctrl_q.ch_en[g]),
      .cnt_i     (cnt_q),
      .duty_sw_o (duty_sw[g]),
      .pwm_o     (pwm_vec[g])
    );
  end

  assign dma_io_rdata = rd_hit_q ? rd_data_q : dma_io_rdata_in;
  assign pwm_out      = pwm_vec;
  assign pwm_wrap     = wrap_q;

endmodule
